// File: rtl/uart_prog_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_prog_tx_pkg
//   Shared types and constants for the host-side UART program loader
//   transmitter: FSM state encoding, FIFO entry layout, sentinel word and a
//   byte-select helper.
// ---------------------------------------------------------------------------
package uart_prog_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    SENT
  } uart_tx_state_t;

  // Word appended after the last program word; the CPU loader treats it as
  // the "start running" marker and raises run_flag.
  localparam logic [31:0] UART_SENTINEL = 32'hFFFF_FFFF;

  // One FIFO entry: the program word plus its end-of-program marker.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

  // Byte idx of a word, byte 0 being the least-significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = w >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/uart_prog_tx_if.sv
// ---------------------------------------------------------------------------
// uart_prog_tx_if
//   valid/ready stream carrying 32-bit program words into uart_prog_tx.
//     s_data   program word
//     s_valid  s_data/s_last valid
//     s_last   word is the final program word
//     s_ready  transmitter can accept a word this cycle
//   master: word source (host side); slave: the transmitter.
// ---------------------------------------------------------------------------
interface uart_prog_tx_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/uart_prog_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_word_fifo
//   Small synchronous FIFO of {last, data[31:0]} entries. Head entry is
//   visible combinationally so the transmitter can pop it straight into its
//   word register in one cycle.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset (empties FIFO)
//     push, push_entry  write an entry (ignored while full)
//     pop               discard the head entry (ignored while empty)
//     head              current head entry
//     full, empty       occupancy flags
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   with DEPTH a power of two.
// ---------------------------------------------------------------------------
module uart_tx_word_fifo
  import uart_prog_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem [DEPTH];

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage has no reset so it maps onto plain RAM; only the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/uart_prog_tx.sv
// ---------------------------------------------------------------------------
// uart_prog_tx
//   Host-side UART transmitter feeding the CPU's io_rx program-load input.
//   Program words arrive on a valid/ready stream, are buffered in a small
//   FIFO, and are sent as four 8N1 frames each, least-significant byte
//   first. After the word flagged last, the SENTINEL word is sent too and
//   done pulses once its final stop bit has left the line.
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     s_if        program word stream (slave side)
//     io_rx       serial line to the CPU, idles high, driven from a flop
//     busy        FIFO non-empty or a frame/sentinel still in progress
//     done        one-cycle pulse after the sentinel's last stop bit
//     bytes_sent  frames completed since reset (wraps)
//   Line timing: io_rx is the registered version of the current state's line
//   level, so the wire trails the FSM by one cycle. A word pushed into an
//   idle, empty block shows its start edge three cycles after the push edge.
// ---------------------------------------------------------------------------
module uart_prog_tx
  import uart_prog_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter logic [31:0] SENTINEL   = UART_SENTINEL
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_prog_tx_if.slave      s_if,
  output logic               io_rx,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bytes_sent
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST   = 3'(STOP_BITS - 1);

  uart_tx_state_t state_reg, state_next;
  logic [15:0]    baud_reg, baud_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [1:0]     byte_idx_reg, byte_idx_next;
  logic [31:0]    word_reg, word_next;
  logic           last_reg, last_next;
  logic           sentinel_reg, sentinel_next;
  logic [7:0]     shift_reg, shift_next;
  logic [15:0]    bytes_sent_reg, bytes_sent_next;
  logic           io_rx_reg;
  logic           line_next;
  logic           done_reg;
  logic           ready_en_reg;

  logic           fifo_push;
  logic           fifo_pop;
  fifo_entry_t    fifo_in;
  fifo_entry_t    fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           baud_zero;

  // ---------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------
  // s_ready stays low while in reset and for the edge that releases it.
  assign s_if.s_ready = ready_en_reg && !fifo_full;
  assign fifo_push    = s_if.s_valid && s_if.s_ready;
  assign fifo_in.last = s_if.s_last;
  assign fifo_in.data = s_if.s_data;

  uart_tx_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------
  assign baud_zero = (baud_reg == 16'd0);

  always_comb begin
    state_next      = state_reg;
    baud_next       = baud_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_idx_next   = byte_idx_reg;
    word_next       = word_reg;
    last_next       = last_reg;
    sentinel_next   = sentinel_reg;
    shift_next      = shift_reg;
    bytes_sent_next = bytes_sent_reg;
    fifo_pop        = 1'b0;
    line_next       = 1'b1;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          word_next     = fifo_head.data;
          last_next     = fifo_head.last;
          byte_idx_next = 2'd0;
          state_next    = LOAD;
        end
      end

      LOAD: begin
        shift_next = word_byte(word_reg, byte_idx_reg);
        baud_next  = BAUD_RELOAD;
        state_next = START;
      end

      START: begin
        line_next = 1'b0;
        if (baud_zero) begin
          baud_next    = BAUD_RELOAD;
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg - 16'd1;
        end
      end

      DATA: begin
        line_next = shift_reg[0];
        if (baud_zero) begin
          baud_next  = BAUD_RELOAD;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = 3'd0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg - 16'd1;
        end
      end

      STOP: begin
        // Each stop bit is timed separately (bit_cnt counts them) so a
        // 16-bit baud counter suffices for any legal BAUD_DIV.
        if (baud_zero) begin
          if (bit_cnt_reg == STOP_LAST) begin
            bytes_sent_next = bytes_sent_reg + 16'd1;
            bit_cnt_next    = 3'd0;
            if (byte_idx_reg != 2'd3) begin
              byte_idx_next = byte_idx_reg + 2'd1;
              state_next    = LOAD;
            end else if (last_reg && !sentinel_reg) begin
              // Chain the sentinel straight after the last program word.
              word_next     = SENTINEL;
              last_next     = 1'b0;
              sentinel_next = 1'b1;
              byte_idx_next = 2'd0;
              state_next    = LOAD;
            end else if (sentinel_reg) begin
              state_next = SENT;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            baud_next    = BAUD_RELOAD;
          end
        end else begin
          baud_next = baud_reg - 16'd1;
        end
      end

      SENT: begin
        sentinel_next = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      baud_reg       <= 16'd0;
      bit_cnt_reg    <= 3'd0;
      byte_idx_reg   <= 2'd0;
      word_reg       <= 32'd0;
      last_reg       <= 1'b0;
      sentinel_reg   <= 1'b0;
      shift_reg      <= 8'd0;
      bytes_sent_reg <= 16'd0;
      io_rx_reg      <= 1'b1;
      done_reg       <= 1'b0;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      baud_reg       <= baud_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      word_reg       <= word_next;
      last_reg       <= last_next;
      sentinel_reg   <= sentinel_next;
      shift_reg      <= shift_next;
      bytes_sent_reg <= bytes_sent_next;
      io_rx_reg      <= line_next;
      // Registered like io_rx so the pulse lines up with the wire: it rises
      // as the sentinel's final stop bit finishes on io_rx.
      done_reg       <= (state_reg == SENT);
      ready_en_reg   <= 1'b1;
    end
  end

  assign io_rx      = io_rx_reg;
  assign done       = done_reg;
  assign bytes_sent = bytes_sent_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_prog_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_tx
//   Directed bench for uart_prog_tx. DUT A runs BAUD_DIV=4, STOP_BITS=1 and
//   is watched by a bit-timed UART receiver; DUT B runs BAUD_DIV=2,
//   STOP_BITS=2 and its line is captured cycle by cycle against an expected
//   waveform.
// ---------------------------------------------------------------------------
module tb_uart_prog_tx;
  import uart_prog_tx_pkg::*;

  localparam int B = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_prog_tx_if a_if ();
  uart_prog_tx_if b_if ();

  logic        a_io_rx, a_busy, a_done;
  logic [15:0] a_bytes;
  logic        b_io_rx, b_busy, b_done;
  logic [15:0] b_bytes;

  uart_prog_tx #(
    .BAUD_DIV (B), .FIFO_DEPTH (4), .STOP_BITS (1), .SENTINEL (32'hFFFF_FFFF)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .s_if (a_if.slave),
    .io_rx (a_io_rx), .busy (a_busy), .done (a_done), .bytes_sent (a_bytes)
  );

  uart_prog_tx #(
    .BAUD_DIV (2), .FIFO_DEPTH (4), .STOP_BITS (2), .SENTINEL (32'hFFFF_FFFF)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .s_if (b_if.slave),
    .io_rx (b_io_rx), .busy (b_busy), .done (b_done), .bytes_sent (b_bytes)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- receiver for DUT A ----------------
  logic [7:0] rx_q[$];
  int         rx_st_q[$];
  logic       rx_busy = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_t = 0;
  int         rx_start = 0;
  logic [7:0] rx_byte = 8'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      rx_busy = 1'b0;
      rx_prev = 1'b1;
    end else if (!rx_busy) begin
      if (rx_prev && !a_io_rx) begin
        rx_busy  = 1'b1;
        rx_start = cyc;
        rx_t     = 0;
      end
      rx_prev = a_io_rx;
    end else begin
      rx_t++;
      if (rx_t == B / 2) check("rx_start_bit", 32'(a_io_rx), 32'd0);
      for (int i = 0; i < 8; i++)
        if (rx_t == B * (i + 1) + B / 2) rx_byte[i] = a_io_rx;
      if (rx_t == 9 * B + B / 2) begin
        check("rx_stop_bit", 32'(a_io_rx), 32'd1);
        rx_q.push_back(rx_byte);
        rx_st_q.push_back(rx_start);
        $display("rx frame %0d: byte %02h start cycle %0d", rx_q.size() - 1, rx_byte, rx_start);
        rx_busy = 1'b0;
        rx_prev = 1'b1;
      end
    end
  end

  int done_cnt = 0;
  int done_cyc = -1;
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- helpers ----------------
  logic [7:0] exp_q[$];

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(word_byte(w, 2'(i)));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_q.delete();
    rx_st_q.delete();
    exp_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(negedge clk);
  endtask

  task automatic push_a(input logic [31:0] d, input logic l, output int pc);
    int g = 0;
    while (!a_if.s_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("push_ready_wait", 32'(a_if.s_ready), 32'd1);
    a_if.s_data  = d;
    a_if.s_last  = l;
    a_if.s_valid = 1'b1;
    @(negedge clk);
    pc = cyc;
    a_if.s_valid = 1'b0;
    $display("push word %08h last=%0d at cycle %0d", d, l, pc);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int g = 0;
    while (rx_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("frame_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic compare_rx(input string tag);
    logic [31:0] got;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_0000;
      check($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
    end
  endtask

  // Expected DUT B line for one frame plus the following LOAD cycle:
  // bit t of the result is io_rx t cycles after the start edge.
  function automatic logic [31:0] frame_vec_b(input logic [7:0] b);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 8; i++) begin
      v[2 + 2 * i] = b[i];
      v[3 + 2 * i] = b[i];
    end
    for (int t = 18; t < 23; t++) v[t] = 1'b1;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int          pc;
  int          g;
  logic        rdy;
  logic [31:0] stream_w[5];
  logic        cap[100];
  logic [31:0] got_v;

  initial begin
    a_if.s_data = '0; a_if.s_valid = 1'b0; a_if.s_last = 1'b0;
    b_if.s_data = '0; b_if.s_valid = 1'b0; b_if.s_last = 1'b0;
    stream_w = '{32'h0102_0304, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_io_rx", 32'(a_io_rx), 32'd1);
    check("rst_s_ready", 32'(a_if.s_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_bytes", 32'(a_bytes), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_s_ready_before_edge", 32'(a_if.s_ready), 32'd0);
    @(negedge clk);
    check("rel_s_ready_after_edge", 32'(a_if.s_ready), 32'd1);

    // Single word, not last
    add_word(32'h1234_5678);
    push_a(32'h1234_5678, 1'b0, pc);
    wait_frames(4, 400);
    compare_rx("w1");
    check("w1_start_latency", 32'(rx_st_q[0] - pc), 32'd3);
    check("w1_byte_period_01", 32'(rx_st_q[1] - rx_st_q[0]), 32'd41);
    check("w1_byte_period_23", 32'(rx_st_q[3] - rx_st_q[2]), 32'd41);
    repeat (10) @(negedge clk);
    check("w1_bytes_sent", 32'(a_bytes), 32'd4);
    check("w1_no_done", 32'(done_cnt), 32'd0);
    check("w1_idle_busy", 32'(a_busy), 32'd0);

    // Last word followed by sentinel
    apply_reset();
    add_word(32'hA5A5_0001);
    add_word(32'hFFFF_FFFF);
    push_a(32'hA5A5_0001, 1'b1, pc);
    wait_frames(8, 800);
    compare_rx("w2");
    check("w2_sentinel_gap", 32'(rx_st_q[4] - rx_st_q[3]), 32'd41);
    repeat (10) @(negedge clk);
    check("w2_done_count", 32'(done_cnt), 32'd1);
    check("w2_done_cycle", 32'(done_cyc - rx_st_q[7]), 32'd40);
    check("w2_bytes_sent", 32'(a_bytes), 32'd8);

    // Five words back-to-back with s_valid held
    apply_reset();
    for (int i = 0; i < 5; i++) add_word(stream_w[i]);
    g = 0;
    pc = 0;
    while (pc < 5 && g < 3000) begin
      a_if.s_data  = stream_w[pc];
      a_if.s_last  = 1'b0;
      a_if.s_valid = 1'b1;
      rdy = a_if.s_ready;
      @(negedge clk);
      g++;
      if (rdy) begin
        $display("stream accept word %0d (%08h) at cycle %0d", pc, stream_w[pc], cyc);
        pc++;
      end
    end
    check("stream_accept_cycles", 32'(g), 32'd5);
    check("stream_ready_full", 32'(a_if.s_ready), 32'd0);
    check("stream_busy", 32'(a_busy), 32'd1);
    a_if.s_valid = 1'b0;
    wait_frames(20, 3000);
    compare_rx("stream");
    repeat (10) @(negedge clk);
    check("stream_bytes_sent", 32'(a_bytes), 32'd20);

    // Reset in the middle of byte 2's data bits
    apply_reset();
    push_a(32'h0BAD_F00D, 1'b0, pc);
    push_a(32'h1111_2222, 1'b0, pc);
    wait_frames(2, 400);
    g = 0;
    // Byte 2 is 0xAD: data bit 1 (low) occupies start+8 .. start+11.
    while (rx_st_q.size() > 0 && cyc != rx_st_q[0] + 82 + 9 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("mid_frame_line_low", 32'(a_io_rx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_io_rx", 32'(a_io_rx), 32'd1);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_bytes", 32'(a_bytes), 32'd0);
    check("mid_rst_s_ready", 32'(a_if.s_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_q.delete();
    rx_st_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("post_rst_fifo_empty", 32'(a_busy), 32'd0);
    add_word(32'hCAFE_BEEF);
    push_a(32'hCAFE_BEEF, 1'b0, pc);
    wait_frames(4, 400);
    compare_rx("post_rst");
    check("post_rst_latency", 32'(rx_st_q[0] - pc), 32'd3);

    // DUT B: two stop bits, BAUD_DIV=2
    apply_reset();
    b_if.s_data  = 32'h0000_C35A;
    b_if.s_last  = 1'b0;
    b_if.s_valid = 1'b1;
    @(negedge clk);
    b_if.s_valid = 1'b0;
    cap[0] = b_io_rx;
    for (int j = 1; j < 100; j++) begin
      @(negedge clk);
      cap[j] = b_io_rx;
    end
    check("b_pre_start_high", 32'(cap[2]), 32'd1);
    for (int n = 0; n < 4; n++) begin
      got_v = 32'd0;
      for (int t = 0; t < 23; t++) got_v[t] = cap[3 + 23 * n + t];
      check($sformatf("b_frame%0d_wave", n), got_v, frame_vec_b(word_byte(32'h0000_C35A, 2'(n))));
      $display("dut_b frame %0d: line %06h", n, got_v);
    end
    check("b_bytes_sent", 32'(b_bytes), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
